// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side drives hazard sources; the controller drives the pipeline controls.
interface hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_use1;
   logic        id_use2;
   logic [4:0]  ex_wreg;
   logic        ex_memread;
   logic        branch_taken;
   logic        dmem_req;
   logic        dmem_ready;
   logic        cnt_clr;

   logic        pc_keep;
   logic        ifid_keep;
   logic        id_keep;
   logic        ex_keep;
   logic        ifid_nop;
   logic        id_nop;
   logic        redirect;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_use1, id_use2, ex_wreg, ex_memread,
             branch_taken, dmem_req, dmem_ready, cnt_clr,
      input  pc_keep, ifid_keep, id_keep, ex_keep, ifid_nop, id_nop,
             redirect, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use1, id_use2, ex_wreg, ex_memread,
             branch_taken, dmem_req, dmem_ready, cnt_clr,
      output pc_keep, ifid_keep, id_keep, ex_keep, ifid_nop, id_nop,
             redirect, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stall, branch flush and load-use stall,
// with saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [1:0]  fcnt_q, fcnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   logic        mem_stall;
   logic        load_use;
   logic        pc_keep, ifid_keep, id_keep, ex_keep;
   logic        ifid_nop, id_nop, redirect;

   // Once waiting, only dmem_ready releases the pipeline.
   assign mem_stall = (state_q == MEM_WAIT) ? !hz.dmem_ready
                                            : (hz.dmem_req && !hz.dmem_ready);

   assign load_use = hz.ex_memread && (hz.ex_wreg != 5'd0) &&
                     ((hz.id_use1 && (hz.id_rs1 == hz.ex_wreg)) ||
                      (hz.id_use2 && (hz.id_rs2 == hz.ex_wreg)));

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path infers a latch.
      state_d   = state_q;
      pending_d = pending_q;
      fcnt_d    = fcnt_q;
      pc_keep   = 1'b0;
      ifid_keep = 1'b0;
      id_keep   = 1'b0;
      ex_keep   = 1'b0;
      ifid_nop  = 1'b0;
      id_nop    = 1'b0;
      redirect  = 1'b0;

      if (rst) begin
         ifid_nop  = 1'b1;
         id_nop    = 1'b1;
         state_d   = RUN;
         pending_d = 1'b0;
         fcnt_d    = 2'd0;
      end else if (mem_stall) begin
         pc_keep   = 1'b1;
         ifid_keep = 1'b1;
         id_keep   = 1'b1;
         ex_keep   = 1'b1;
         pending_d = pending_q || hz.branch_taken;
         state_d   = MEM_WAIT;
      end else if (state_q == MEM_WAIT) begin
         // Release cycle: an owed branch is redirected in the following FLUSH cycle.
         pending_d = pending_q || hz.branch_taken;
         state_d   = (pending_q || hz.branch_taken) ? FLUSH : RUN;
      end else if (hz.branch_taken || pending_q) begin
         redirect  = 1'b1;
         ifid_nop  = 1'b1;
         id_nop    = 1'b1;
         pending_d = 1'b0;
         fcnt_d    = FLUSH_LOAD;
         state_d   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (state_q == FLUSH) begin
         ifid_nop = 1'b1;
         fcnt_d   = (fcnt_q != 2'd0) ? fcnt_q - 2'd1 : 2'd0;
         state_d  = (fcnt_q <= 2'd1) ? RUN : FLUSH;
      end else if (load_use) begin
         pc_keep   = 1'b1;
         ifid_keep = 1'b1;
         id_nop    = 1'b1;
      end

      if (hz.cnt_clr) begin
         stall_cnt_d = 16'd0;
         flush_cnt_d = 16'd0;
      end else begin
         stall_cnt_d = (pc_keep && stall_cnt_q != CNT_MAX) ? stall_cnt_q + 16'd1 : stall_cnt_q;
         flush_cnt_d = (redirect && flush_cnt_q != CNT_MAX) ? flush_cnt_q + 16'd1 : flush_cnt_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pending_q   <= 1'b0;
         fcnt_q      <= 2'd0;
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.pc_keep   = pc_keep;
   assign hz.ifid_keep = ifid_keep;
   assign hz.id_keep   = id_keep;
   assign hz.ex_keep   = ex_keep;
   assign hz.ifid_nop  = ifid_nop;
   assign hz.id_nop    = id_nop;
   assign hz.redirect  = redirect;
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule
